// File: rtl/seg7_scan_display.sv
// Multiplexed NUM_DIGITS-digit 7-segment scan driver with shadowed value,
// per-digit blanking, leading-zero suppression, decimal points and frame strobe.
module seg7_scan_display #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_CNT = 100000,
   parameter int IDX_W       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              cathode,
   output logic                    dp,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_done
);

   localparam int PW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;

   logic [PW-1:0]           presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              cathode_q, cathode_d;
   logic                    dp_q, dp_d;
   logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
   logic                    frame_done_q, frame_done_d;

   logic                  tc;
   logic                  last;
   logic [NUM_DIGITS-1:0] lz_zero;
   logic                  acc;
   logic [3:0]            nib_sel;
   logic                  dp_sel;
   logic                  en_sel;
   logic                  lz_sel;
   logic                  blank;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      tc      = (presc_q == PW'(REFRESH_CNT - 1));
      last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
      presc_d = tc ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (tc) begin
         idx_d = last ? '0 : idx_q + IDX_W'(1);
      end
      frame_done_d = tc && last;

      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
      end
   end

   // lz_zero[i]: nibbles i..NUM_DIGITS-1 are all zero
   always_comb begin
      lz_zero = '0;
      acc     = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc        = acc & (shadow_val_q[i*4 +: 4] == 4'h0);
         lz_zero[i] = acc;
      end
   end

   always_comb begin
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      en_sel  = 1'b0;
      lz_sel  = 1'b0;
      anode_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_sel    = shadow_val_q[i*4 +: 4];
            dp_sel     = shadow_dp_q[i];
            en_sel     = digit_en[i];
            lz_sel     = lz_zero[i];
            anode_d[i] = 1'b0;
         end
      end
      // blanked digits keep their anode low so every slot has equal on-time
      blank       = ~en_sel | (lz_blank & (idx_q != '0) & lz_sel);
      cathode_d   = blank ? 7'b1111111 : seg7(nib_sel);
      dp_d        = blank ? 1'b1 : ~dp_sel;
      digit_idx_d = idx_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         anode_q      <= '1;
         cathode_q    <= 7'b1111111;
         dp_q         <= 1'b1;
         digit_idx_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         anode_q      <= anode_d;
         cathode_q    <= cathode_d;
         dp_q         <= dp_d;
         digit_idx_q  <= digit_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign anode      = anode_q;
   assign cathode    = cathode_q;
   assign dp         = dp_q;
   assign digit_idx  = digit_idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: 4 digits, 4 clk per slot.
module tb_seg7_scan_display;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SC = 7'b0110001;
   localparam logic [6:0] BL = 7'b1111111;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        lz_blank;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_done;

   seg7_scan_display #(
      .NUM_DIGITS (4),
      .REFRESH_CNT(4),
      .IDX_W      (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .value     (value),
      .load      (load),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .lz_blank  (lz_blank),
      .anode     (anode),
      .cathode   (cathode),
      .dp        (dp),
      .digit_idx (digit_idx),
      .frame_done(frame_done)
   );

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] an;
      logic [6:0] cat;
      logic       dp;
      logic [1:0] idx;
      logic       fd;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   checks;
   int   errors;
   string tname;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   // Monitor: compares whenever an expectation for the current cycle is queued
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge rst);
         #1;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (anode !== e.an || cathode !== e.cat || dp !== e.dp ||
                digit_idx !== e.idx || frame_done !== e.fd) begin
               errors++;
               $display("FAIL %s n=%0d: got an=%b cat=%b dp=%b idx=%0d fd=%b, want an=%b cat=%b dp=%b idx=%0d fd=%b",
                        e.name, e.cyc, anode, cathode, dp, digit_idx,
                        frame_done, e.an, e.cat, e.dp, e.idx, e.fd);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Expect digit shown after the next edge, derived from the slot number
   task automatic push_tick(input logic [6:0] c, input logic dv);
      exp_t e;
      int   n;
      int   d;
      n      = cyc + 1;
      d      = ((n - 1) / 4) % 4;
      e.name = tname;
      e.cyc  = n;
      e.an   = 4'b1111 & ~(4'b0001 << d);
      e.cat  = c;
      e.dp   = dv;
      e.idx  = 2'(d);
      e.fd   = (n % 16 == 0);
      q.push_back(e);
      tick();
   endtask

   task automatic run_slots(input int k0, input int k1,
                            input logic [6:0] c0, input logic [6:0] c1,
                            input logic [6:0] c2, input logic [6:0] c3,
                            input logic [3:0] dpx);
      logic [6:0] t[4];
      t[0] = c0;
      t[1] = c1;
      t[2] = c2;
      t[3] = c3;
      for (int k = k0; k <= k1; k++) push_tick(t[k/4], dpx[k/4]);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      tick();
      load = 1'b0;
      ticks(15);
   endtask

   initial begin
      exp_t e;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst      = 1'b0;
      value    = 16'h0000;
      load     = 1'b0;
      dp_in    = 4'b0000;
      digit_en = 4'b1111;
      lz_blank = 1'b0;

      tname = "reset";
      e = '{name: tname, cyc: 0, an: 4'b1111, cat: BL, dp: 1'b1,
            idx: 2'd0, fd: 1'b0};
      q.push_back(e);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      tname = "scan_zero";
      run_slots(0, 15, S0, S0, S0, S0, 4'b1111);
      run_slots(0, 15, S0, S0, S0, S0, 4'b1111);

      tname = "hex_a5c3";
      do_load(16'hA5C3, 4'b0100);
      run_slots(0, 15, S3, SC, S5, SA, 4'b1011);

      tname = "lz_0007";
      lz_blank = 1'b1;
      do_load(16'h0007, 4'b0000);
      run_slots(0, 15, S7, BL, BL, BL, 4'b1111);

      tname = "no_load";
      value = 16'h1234;
      run_slots(0, 15, S7, BL, BL, BL, 4'b1111);

      tname = "mid_load";
      push_tick(S7, 1'b1);
      push_tick(S7, 1'b1);
      load = 1'b1;
      push_tick(S7, 1'b1);
      load = 1'b0;
      push_tick(S4, 1'b1);
      run_slots(4, 15, S4, S3, S2, S1, 4'b1111);

      tname = "digit_en";
      lz_blank = 1'b0;
      digit_en = 4'b1010;
      do_load(16'h9999, 4'b1111);
      run_slots(0, 15, BL, S9, BL, S9, 4'b0101);

      tname = "lz_inner0";
      digit_en = 4'b1111;
      lz_blank = 1'b1;
      do_load(16'h0102, 4'b0000);
      run_slots(0, 15, S2, S0, S1, BL, 4'b1111);

      tname = "lz_all0";
      do_load(16'h0000, 4'b0000);
      run_slots(0, 15, S0, BL, BL, BL, 4'b1111);

      tname = "pre_reset";
      lz_blank = 1'b0;
      do_load(16'hA5C3, 4'b0000);
      run_slots(0, 9, S3, SC, S5, SA, 4'b1111);

      tname = "async_rst";
      #6;
      e = '{name: tname, cyc: cyc, an: 4'b1111, cat: BL, dp: 1'b1,
            idx: 2'd0, fd: 1'b0};
      q.push_back(e);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0;
      rst = 1'b1;

      tname = "restart";
      run_slots(0, 15, S0, S0, S0, S0, 4'b1111);

      @(negedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed 7-segment display driver.
- Generalises the current two-digit toggle display to NUM_DIGITS digits with a programmable refresh rate and a load-captured shadow register.
- Adds per-digit blanking, leading-zero suppression, decimal points and a frame-done strobe.
- Sits at the top level between the core result bus (register-file hardwire / ALU result) and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16).
- REFRESH_CNT, 100000, clk cycles each digit is lit (must be ≥2).
- IDX_W, 4, width of digit_idx; must satisfy 2^IDX_W ≥ NUM_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex nibbles to display; nibble i drives digit i (digit 0 = least significant)
- load  in  1  capture value and dp_in into the shadow registers on this clk edge
- dp_in  in  NUM_DIGITS  decimal-point request per digit (1 = on)
- digit_en  in  NUM_DIGITS  per-digit enable (0 = digit blank); sampled live, not shadowed
- lz_blank  in  1  leading-zero suppression enable
- anode  out  NUM_DIGITS  active-low anode drive; at most one bit low
- cathode  out  7  active-low segments {a,b,c,d,e,f,g}
- dp  out  1  active-low decimal point
- digit_idx  out  IDX_W  index of the digit currently driven
- frame_done  out  1  one-cycle pulse when the last digit finishes its slot

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, idx=0, shadow value=0, shadow dp=0.
  - anode all 1, cathode 7'b1111111, dp=1, digit_idx=0, frame_done=0.
- Prescaler:
  - Counts 0..REFRESH_CNT-1. Terminal count (TC) is when prescaler==REFRESH_CNT-1; it then wraps to 0.
  - On TC, idx advances by 1. It wraps to 0 after NUM_DIGITS-1.
  - frame_done=1 in the cycle after the TC at which idx was NUM_DIGITS-1; 0 otherwise.
- Shadow:
  - On load=1 at a clk edge, value and dp_in are captured; otherwise held.
  - Load takes effect on outputs at the next output update, with no frame re-sync. Prescaler and idx are unaffected.
- Output stage: registered, updated every clk from the current idx and shadow, so outputs lag idx by exactly 1 cycle.
  - digit_idx = idx.
  - anode = all 1 except bit idx = 0.
  - cathode = active-low encoding of shadow nibble[idx]:
    0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - dp = ~shadow_dp[idx].
- Blanking: a blanked digit keeps its anode driven low for uniform brightness timing, with cathode=1111111 and dp=1. A digit is blanked if either:
  - digit_en[idx]=0; or
  - lz_blank=1, idx>0, and all shadow nibbles idx..NUM_DIGITS-1 are zero.
- Digit 0 is never suppressed by lz_blank, so the value 0 displays "0".
- A digit whose shadow dp bit is set is still subject to blanking; blanking overrides dp.
- NUM_DIGITS=1: idx is constant 0, and frame_done pulses once every REFRESH_CNT cycles.
- Reset mid-frame forces all outputs dark immediately and restarts scanning at digit 0 after release.

Test Plan:
1. NUM_DIGITS=4, REFRESH_CNT=4, reset then release, no load -> anode cycles 1110,1101,1011,0111 with each pattern held 4 clk; every cathode=0000001; frame_done pulses once every 16 clk.
2. Load value=16'hA5C3, dp_in=4'b0100, lz_blank=0 -> across the slots for digits 0,1,2,3: cathode = 0000110, 0110001, 0100100, 0001000 (3,C,5,A); dp low only in digit 2's slot.
3. Load value=16'h0007, lz_blank=1 -> digit 0 shows 0001111; digits 1..3 cathode=1111111; anodes still scan.
4. Change value to 16'h1234 without asserting load -> display unchanged. Pulse load once mid-slot -> new nibble appears one clk after the load edge, and slot timing is unchanged.
5. digit_en=4'b1010 with value=16'h9999 -> digits 1 and 3 show 0000100; digits 0 and 2 show cathode=1111111 and dp=1.
6. Assert rst mid-slot while digit 2 is active -> anode=1111 and cathode=1111111 in the same cycle, without waiting for a clk edge. After release, scanning restarts at digit 0 with shadow=0.
